apb_periph_demux: RTL

//  Parametrised APB 1-to-NB_PORTS peripheral demux; successor of the fixed-map SoC peripheral bus node.

---
 rtl/apb_demux_pkg.sv | 26 ++
 rtl/apb_addr_decoder.sv | 32 +++
 rtl/apb_periph_demux.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/apb_demux_pkg.sv
// Shared types for the APB peripheral demux: FSM states, error codes, index width helper.
// Latency: n/a (types only).  Backpressure: n/a.
package apb_demux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SETUP,
        ACCESS,
        RESP,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_MISS    = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_SLV     = 2'b11
    } err_code_e;

    // Keeps the port index at least one bit wide for single-port builds.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Priority range match of an address against per-port start/end tables; lowest enabled index wins.
// Latency: combinational.  Backpressure: none, pure function of its inputs.
module apb_addr_decoder
    import apb_demux_pkg::*;
#(
    parameter int NB_PORTS       = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_W          = 4
) (
    input  logic [APB_ADDR_WIDTH-1:0]          addr,
    input  logic [NB_PORTS*APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_PORTS*APB_ADDR_WIDTH-1:0] end_addr,
    input  logic [NB_PORTS-1:0]                port_en,
    output logic                               hit,
    output logic [IDX_W-1:0]                   idx
);

    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NB_PORTS - 1; i >= 0; i--) begin
            if (port_en[i] &&
                addr >= start_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                addr <= end_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_demux.sv
// APB 1-to-NB_PORTS demux with registered range decode, port enables, response timeout and error codes.
// Latency: setup->pready 4 cycles for a 0-wait slave, 2 cycles on decode miss.  Backpressure: slave pready stalls ACCESS up to the timeout.
module apb_periph_demux
    import apb_demux_pkg::*;
#(
    parameter int NB_PORTS       = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
    input  logic                               pwrite_i,
    input  logic                               psel_i,
    input  logic                               penable_i,
    output logic [APB_DATA_WIDTH-1:0]          prdata_o,
    output logic                               pready_o,
    output logic                               pslverr_o,
    input  logic [NB_PORTS*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_PORTS*APB_ADDR_WIDTH-1:0] end_addr_i,
    input  logic [NB_PORTS-1:0]                port_en_i,
    output logic [APB_ADDR_WIDTH-1:0]          m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          m_pwdata_o,
    output logic                               m_pwrite_o,
    output logic [NB_PORTS-1:0]                m_psel_o,
    output logic                               m_penable_o,
    input  logic [NB_PORTS*APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_PORTS-1:0]                m_pready_i,
    input  logic [NB_PORTS-1:0]                m_pslverr_i,
    output logic                               err_o,
    output logic [1:0]                         err_code_o
);

    localparam int IDX_W = idx_width(NB_PORTS);

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    err_code_e                 code_q;
    err_code_e                 err_code_q;
    logic                      abort_q;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic                      slave_rdy;
    logic                      slave_err;
    logic [APB_DATA_WIDTH-1:0] slave_rdata;
    logic                      timeout;
    logic                      rsp_vld;
    logic                      start_req;

    apb_addr_decoder #(
        .NB_PORTS       (NB_PORTS),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_W          (IDX_W)
    ) u_decoder (
        .addr       (addr_q),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .port_en    (port_en_i),
        .hit        (dec_hit),
        .idx        (dec_idx)
    );

    assign start_req   = psel_i && !penable_i;
    assign slave_rdy   = m_pready_i[idx_q];
    assign slave_err   = m_pslverr_i[idx_q];
    assign slave_rdata = m_prdata_i[int'(idx_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];

    // Counts ACCESS cycles; fires on the last allowed cycle so the next edge leaves ACCESS.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
        logic [TO_W-1:0] to_cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                to_cnt_q <= '0;
            end else if (state_q == ACCESS) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
        end

        assign timeout = (state_q == ACCESS) && (to_cnt_q == TO_LAST);
    end else begin : g_no_timeout
        assign timeout = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = DECODE;
            DECODE:  state_d = dec_hit ? SETUP : ERR;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (slave_rdy || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            rdata_q    <= '0;
            code_q     <= ERR_NONE;
            abort_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (state_q == IDLE && start_req) begin
                addr_q  <= paddr_i;
                wdata_q <= pwdata_i;
                write_q <= pwrite_i;
            end
            if (state_q == DECODE) begin
                idx_q   <= dec_idx;
                rdata_q <= '0;
                code_q  <= dec_hit ? ERR_NONE : ERR_MISS;
            end
            // Ready has priority over a timeout landing in the same cycle.
            if (state_q == ACCESS) begin
                if (slave_rdy) begin
                    rdata_q <= write_q ? '0 : slave_rdata;
                    code_q  <= slave_err ? ERR_SLV : ERR_NONE;
                end else if (timeout) begin
                    rdata_q <= '0;
                    code_q  <= ERR_TIMEOUT;
                end
            end
            // An upstream master that gives up mid-transfer gets no response.
            if (state_q == IDLE) begin
                abort_q <= 1'b0;
            end else if ((state_q == DECODE || state_q == SETUP || state_q == ACCESS) && !psel_i) begin
                abort_q <= 1'b1;
            end
            if (err_o) begin
                err_code_q <= code_q;
            end
        end
    end

    always_comb begin
        rsp_vld     = (state_q == RESP || state_q == ERR) && !abort_q && psel_i;
        pready_o    = rsp_vld;
        prdata_o    = rsp_vld ? rdata_q : '0;
        pslverr_o   = rsp_vld && (code_q != ERR_NONE);
        err_o       = rsp_vld && (code_q != ERR_NONE);
        m_psel_o    = (state_q == SETUP || state_q == ACCESS) ? (NB_PORTS'(1) << idx_q) : '0;
        m_penable_o = (state_q == ACCESS);
    end

    assign m_paddr_o  = addr_q;
    assign m_pwdata_o = wdata_q;
    assign m_pwrite_o = write_q;
    assign err_code_o = err_code_q;

endmodule
